multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier.
- Multiplies an m-bit operand A by an n-bit operand B over several clock cycles and presents the (m+n)-bit product on C.
- Free-running: no start/done handshake. After reset it repeatedly samples A/B, computes, and updates C.
- Used as a small area-efficient arithmetic datapath block.

---
 rtl/multiplier_if.sv | 13 +
 rtl/multiplier.sv | 86 ++++++++
 tb/tb_multiplier.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// Operand/product bundle for the shift-and-add multiplier.
// The multiplier consumes the slave side; the environment drives the master side.
interface multiplier_if #(
    parameter int m = 4,
    parameter int n = 4
);
    logic [m-1:0]   A;
    logic [n-1:0]   B;
    logic [m+n-1:0] C;

    modport master (output A, output B, input C);
    modport slave  (input A, input B, output C);
endinterface

// File: rtl/multiplier.sv
// Free-running sequential unsigned shift-and-add multiplier.
// Each period samples A/B, iterates n times, then publishes the product on C.
//
//   state | meaning
//   LOAD  | capture A and B, clear upper accumulator and iteration count
//   RUN   | conditional add of multiplicand, shift right; n cycles
//   DONE  | publish accumulator low m+n bits to C
module multiplier #(
    parameter int m = 4,
    parameter int n = 4
) (
    input  logic clk,
    input  logic rst,
    multiplier_if.slave bus
);
    localparam int CW = (n < 1) ? 1 : $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [m-1:0]    mcand;
    logic [m+n:0]    acc;
    logic [m+n:0]    acc_next;
    logic [m:0]      addend;
    logic [m:0]      sum;
    logic [CW-1:0]   cnt;
    logic [m+n-1:0]  c_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // (m+1)-bit sum keeps the carry so it lands in the top accumulator bit before the shift.
    always_comb begin
        addend   = acc[0] ? {1'b0, mcand} : '0;
        sum      = acc[m+n:n] + addend;
        acc_next = {sum, acc[n-1:0]} >> 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            c_q   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    mcand <= bus.A;
                    acc   <= {{(m + 1){1'b0}}, bus.B};
                    cnt   <= '0;
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    c_q <= acc[m+n-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.C = c_q;
endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the 4x4 shift-and-add multiplier.
// One task per scenario; outputs sampled on the falling edge.
module tb_multiplier;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multiplier_if #(.m(4), .n(4)) bus ();

    multiplier #(.m(4), .n(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset pulse with operands set up; returns on the falling edge where rst releases,
    // so the next rising edge is the LOAD edge.
    task automatic pulse_reset(input logic [3:0] a_val, input logic [3:0] b_val);
        @(negedge clk);
        bus.A = a_val;
        bus.B = b_val;
        rst   = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
    endtask

    task automatic test_reset();
        bus.A = 4'd0;
        bus.B = 4'd0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.C !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold: C=%0d expected=0", bus.C);
        end
    endtask

    task automatic test_max();
        pulse_reset(4'hF, 4'hF);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.C !== 8'd0) begin
            errors++;
            $display("FAIL max_before_done: C=%0d expected=0", bus.C);
        end
        @(negedge clk);
        checks++;
        if (bus.C !== 8'd225) begin
            errors++;
            $display("FAIL max_product: C=%0d expected=225", bus.C);
        end
    endtask

    task automatic test_small_hold();
        pulse_reset(4'd3, 4'd3);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.C !== 8'd9) begin
            errors++;
            $display("FAIL small_product: C=%0d expected=9", bus.C);
        end
        bus.A = 4'd2;
        bus.B = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.C !== 8'd9) begin
                errors++;
                $display("FAIL small_hold[%0d]: C=%0d expected=9", i, bus.C);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.C !== 8'd4) begin
            errors++;
            $display("FAIL small_next_period: C=%0d expected=4", bus.C);
        end
    endtask

    task automatic test_shifted();
        pulse_reset(4'b1100, 4'b0010);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.C !== 8'd24) begin
            errors++;
            $display("FAIL shifted_product: C=%0d expected=24", bus.C);
        end
    endtask

    task automatic test_zero_one();
        logic [3:0] a_vec [5];
        logic [3:0] b_vec [5];
        logic [7:0] exp_c [5];
        a_vec = '{4'h0, 4'hF, 4'h1, 4'hF, 4'h1};
        b_vec = '{4'hF, 4'h0, 4'h1, 4'h1, 4'hF};
        exp_c = '{8'd0, 8'd0, 8'd1, 8'd15, 8'd15};
        for (int i = 0; i < 5; i++) begin
            pulse_reset(a_vec[i], b_vec[i]);
            repeat (6) @(negedge clk);
            checks++;
            if (bus.C !== exp_c[i]) begin
                errors++;
                $display("FAIL zero_one[%0d]: A=%0d B=%0d C=%0d expected=%0d",
                         i, a_vec[i], b_vec[i], bus.C, exp_c[i]);
            end
        end
    endtask

    task automatic test_operand_change();
        pulse_reset(4'd3, 4'd3);
        @(negedge clk);
        bus.A = 4'd15;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.C !== 8'd9) begin
            errors++;
            $display("FAIL change_current: C=%0d expected=9", bus.C);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.C !== 8'd45) begin
            errors++;
            $display("FAIL change_next: C=%0d expected=45", bus.C);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_reset(4'hF, 4'hF);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.C !== 8'd225) begin
            errors++;
            $display("FAIL midrun_setup: C=%0d expected=225", bus.C);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.C !== 8'd0) begin
            errors++;
            $display("FAIL midrun_async_clear: C=%0d expected=0", bus.C);
        end
        bus.A = 4'd5;
        bus.B = 4'd7;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.C !== 8'd0) begin
            errors++;
            $display("FAIL midrun_before_done: C=%0d expected=0", bus.C);
        end
        @(negedge clk);
        checks++;
        if (bus.C !== 8'd35) begin
            errors++;
            $display("FAIL midrun_restart: C=%0d expected=35", bus.C);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        bus.A  = 4'd0;
        bus.B  = 4'd0;
        test_reset();
        test_max();
        test_small_hold();
        test_shifted();
        test_zero_one();
        test_operand_change();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end
endmodule
